// File: rtl/rc4_sbox_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : rc4_sbox_ctrl_if
//  Purpose  : Groups the key-store, keystream handshake and S-box RAM port
//             signals of the RC4 S-box sequencer.
//             The 'master' modport is the sequencer side.
//             The 'slave' modport is the surrounding key store, consumer
//             and RAM side.
//  Revision : 1.0  initial release
// ============================================================================
interface rc4_sbox_ctrl_if;
    logic       start;
    logic [7:0] key_len_m1;
    logic [7:0] key_idx;
    logic [7:0] key_byte;
    logic       busy;
    logic       ks_ready;
    logic       ks_req;
    logic       ks_valid;
    logic [7:0] ks_byte;
    logic [7:0] ram_addr;
    logic       ram_we;
    logic [7:0] ram_wdata;
    logic [7:0] ram_rdata;

    modport master (
        input  start, key_len_m1, key_byte, ks_req, ram_rdata,
        output key_idx, busy, ks_ready, ks_valid, ks_byte,
               ram_addr, ram_we, ram_wdata
    );

    modport slave (
        output start, key_len_m1, key_byte, ks_req, ram_rdata,
        input  key_idx, busy, ks_ready, ks_valid, ks_byte,
               ram_addr, ram_we, ram_wdata
    );
endinterface
`default_nettype wire

// File: rtl/rc4_sbox_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : rc4_sbox_ctrl
//  Purpose  : Owns the 256x8 RC4 S-box RAM.
//             Sequence: S-box initialisation, then key scheduling against an
//             external key store, then one keystream byte per request.
//  Revision : 1.0  initial release
// ============================================================================
module rc4_sbox_ctrl (
    input  logic               clk,
    input  logic               rst,
    rc4_sbox_ctrl_if.master    bus_io
);
    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_INIT   = 4'd1,
        ST_K_RD_I = 4'd2,
        ST_K_RD_J = 4'd3,
        ST_K_WR_I = 4'd4,
        ST_K_WR_J = 4'd5,
        ST_READY  = 4'd6,
        ST_P_RD_I = 4'd7,
        ST_P_RD_J = 4'd8,
        ST_P_WR_I = 4'd9,
        ST_P_WR_J = 4'd10,
        ST_P_RD_K = 4'd11,
        ST_P_OUT  = 4'd12
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] n_q, n_d;
    logic [7:0] i_q, i_d;
    logic [7:0] j_q, j_d;
    logic [7:0] key_idx_q, key_idx_d;
    logic [7:0] klen_q, klen_d;
    logic [7:0] si_q, si_d;
    logic [7:0] sj_q, sj_d;
    logic [7:0] ks_byte_q, ks_byte_d;
    logic       ks_valid_q, ks_valid_d;

    logic       w_busy;
    logic       w_ks_ready;
    logic [7:0] w_ram_addr;
    logic       w_ram_we;
    logic [7:0] w_ram_wdata;

    // State and datapath registers, cleared asynchronously (RAM is not)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            n_q        <= 8'd0;
            i_q        <= 8'd0;
            j_q        <= 8'd0;
            key_idx_q  <= 8'd0;
            klen_q     <= 8'd0;
            si_q       <= 8'd0;
            sj_q       <= 8'd0;
            ks_byte_q  <= 8'd0;
            ks_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            n_q        <= n_d;
            i_q        <= i_d;
            j_q        <= j_d;
            key_idx_q  <= key_idx_d;
            klen_q     <= klen_d;
            si_q       <= si_d;
            sj_q       <= sj_d;
            ks_byte_q  <= ks_byte_d;
            ks_valid_q <= ks_valid_d;
        end
    end

    // Next-state, datapath update and RAM port drive for every sequencer step
    always_comb begin
        state_d     = state_q;
        n_d         = n_q;
        i_d         = i_q;
        j_d         = j_q;
        key_idx_d   = key_idx_q;
        klen_d      = klen_q;
        si_d        = si_q;
        sj_d        = sj_q;
        ks_byte_d   = ks_byte_q;
        ks_valid_d  = 1'b0;
        w_busy      = 1'b0;
        w_ks_ready  = 1'b0;
        w_ram_addr  = 8'd0;
        w_ram_we    = 1'b0;
        w_ram_wdata = 8'd0;

        case (state_q)
            ST_IDLE: begin
                if (bus_io.start) begin
                    klen_d    = bus_io.key_len_m1;
                    n_d       = 8'd0;
                    i_d       = 8'd0;
                    j_d       = 8'd0;
                    key_idx_d = 8'd0;
                    state_d   = ST_INIT;
                end
            end
            ST_INIT: begin
                w_busy      = 1'b1;
                w_ram_we    = 1'b1;
                w_ram_addr  = n_q;
                w_ram_wdata = n_q;
                n_d         = n_q + 8'd1;
                if (n_q == 8'hFF) begin
                    i_d     = 8'd0;
                    state_d = ST_K_RD_I;
                end
            end
            ST_K_RD_I: begin
                w_busy     = 1'b1;
                w_ram_addr = i_q;
                state_d    = ST_K_RD_J;
            end
            ST_K_RD_J: begin
                // The new j is fed straight to the RAM address in this state
                w_busy     = 1'b1;
                si_d       = bus_io.ram_rdata;
                j_d        = j_q + bus_io.ram_rdata + bus_io.key_byte;
                w_ram_addr = j_d;
                state_d    = ST_K_WR_I;
            end
            ST_K_WR_I: begin
                w_busy      = 1'b1;
                sj_d        = bus_io.ram_rdata;
                w_ram_we    = 1'b1;
                w_ram_addr  = i_q;
                w_ram_wdata = bus_io.ram_rdata;
                state_d     = ST_K_WR_J;
            end
            ST_K_WR_J: begin
                w_busy      = 1'b1;
                w_ram_we    = 1'b1;
                w_ram_addr  = j_q;
                w_ram_wdata = si_q;
                key_idx_d   = (key_idx_q == klen_q) ? 8'd0 : key_idx_q + 8'd1;
                if (i_q == 8'hFF) begin
                    i_d     = 8'd0;
                    j_d     = 8'd0;
                    state_d = ST_READY;
                end else begin
                    i_d     = i_q + 8'd1;
                    state_d = ST_K_RD_I;
                end
            end
            ST_READY: begin
                w_ks_ready = 1'b1;
                if (bus_io.start) begin
                    klen_d    = bus_io.key_len_m1;
                    n_d       = 8'd0;
                    i_d       = 8'd0;
                    j_d       = 8'd0;
                    key_idx_d = 8'd0;
                    state_d   = ST_INIT;
                end else if (bus_io.ks_req) begin
                    i_d     = i_q + 8'd1;
                    state_d = ST_P_RD_I;
                end
            end
            ST_P_RD_I: begin
                w_ram_addr = i_q;
                state_d    = ST_P_RD_J;
            end
            ST_P_RD_J: begin
                si_d       = bus_io.ram_rdata;
                j_d        = j_q + bus_io.ram_rdata;
                w_ram_addr = j_d;
                state_d    = ST_P_WR_I;
            end
            ST_P_WR_I: begin
                sj_d        = bus_io.ram_rdata;
                w_ram_we    = 1'b1;
                w_ram_addr  = i_q;
                w_ram_wdata = bus_io.ram_rdata;
                state_d     = ST_P_WR_J;
            end
            ST_P_WR_J: begin
                w_ram_we    = 1'b1;
                w_ram_addr  = j_q;
                w_ram_wdata = si_q;
                state_d     = ST_P_RD_K;
            end
            ST_P_RD_K: begin
                w_ram_addr = si_q + sj_q;
                state_d    = ST_P_OUT;
            end
            ST_P_OUT: begin
                // A request seen while the byte is delivered is accepted here.
                // This keeps a held request at one byte every six cycles.
                w_ks_ready = 1'b1;
                ks_byte_d  = bus_io.ram_rdata;
                ks_valid_d = 1'b1;
                if (bus_io.ks_req) begin
                    i_d     = i_q + 8'd1;
                    state_d = ST_P_RD_I;
                end else begin
                    state_d = ST_READY;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus_io.key_idx   = key_idx_q;
    assign bus_io.busy      = w_busy;
    assign bus_io.ks_ready  = w_ks_ready;
    assign bus_io.ks_valid  = ks_valid_q;
    assign bus_io.ks_byte   = ks_byte_q;
    assign bus_io.ram_addr  = w_ram_addr;
    assign bus_io.ram_we    = w_ram_we;
    assign bus_io.ram_wdata = w_ram_wdata;

endmodule
`default_nettype wire
